// File: rtl/mem_pkg.sv
// mem_pkg: types and constants shared by the memory-access stage.
//   state_e          IDLE / BUSY state encoding of the access FSM
//   LB..SW           funct3 encodings for loads and stores
//   DEFAULT_TIMEOUT  default bound on the wait for dmem_ack
//   helpers          alignment check, store byte enables, store lane replication
package mem_pkg;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    localparam int DEFAULT_TIMEOUT = 255;

    // size is funct3[1:0]: 00 byte, 01 half, anything else is treated as a word
    function automatic logic is_aligned(logic [1:0] size, logic [1:0] a);
        case (size)
            2'b00:   return 1'b1;
            2'b01:   return ~a[0];
            default: return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_en(logic [1:0] size, logic [1:0] a);
        case (size)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate narrow store data into every lane so the byte enables alone
    // decide which bytes the memory updates.
    function automatic logic [31:0] store_data(logic [1:0] size, logic [31:0] d);
        case (size)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// mem_load_align: combinational load-data lane select and extension.
//   rdata_i   raw 32-bit word returned by data memory
//   addr_i    byte offset of the access within the word
//   funct3_i  load type (LB/LH/LW/LBU/LHU)
//   data_o    selected lane(s), sign- or zero-extended to 32 bits
module mem_load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
            LH:      data_o = {{16{half_sel[15]}}, half_sel};
            LBU:     data_o = {24'h0, byte_sel};
            LHU:     data_o = {16'h0, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MM pipeline stage driving a request/ack data memory port.
//   clk, rst_n             clock, asynchronous active-low reset
//   ex_valid ... funct3_in EX/MM register contents, qualified by ex_valid
//   flush                  squash the operation in this stage
//   dmem_*                 data memory request port (word address, byte enables)
//   wb_valid ... rd_out    MM/WB register contents
//   stall_out              high while a memory access is outstanding
//   misaligned_err, bus_err one-cycle error pulses, coincident with wb_valid
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,   // only 32 is supported
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    input  logic                  reg_write_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [DATA_WIDTH-1:0] alu_result_in,
    input  logic [DATA_WIDTH-1:0] write_data_in,
    input  logic [4:0]            rd_in,
    input  logic [2:0]            funct3_in,
    input  logic                  flush,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [DATA_WIDTH-1:0] dmem_addr,
    output logic [DATA_WIDTH-1:0] dmem_wdata,
    output logic [3:0]            dmem_be,
    input  logic [DATA_WIDTH-1:0] dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  wb_valid,
    output logic                  reg_write_out,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic [DATA_WIDTH-1:0] alu_result_out,
    output logic [4:0]            rd_out,
    output logic                  stall_out,
    output logic                  misaligned_err,
    output logic                  bus_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic                  we_q, we_d, regw_q, regw_d, squash_q, squash_d;
    logic [4:0]            rd_q, rd_d;
    logic [2:0]            f3_q, f3_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  wbv_q, wbv_d, wbrw_q, wbrw_d, mis_q, mis_d, berr_q, berr_d;
    logic [DATA_WIDTH-1:0] mdata_q, mdata_d, alu_q, alu_d;
    logic [4:0]            rdo_q, rdo_d;

    logic [DATA_WIDTH-1:0] load_data;
    logic                  kill;

    mem_load_align u_align (
        .rdata_i  (dmem_rdata),
        .addr_i   (addr_q[1:0]),
        .funct3_i (f3_q),
        .data_o   (load_data)
    );

    // A flush arriving in the same cycle as the ack squashes just like an earlier one.
    assign kill = squash_q | flush;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        be_d     = be_q;
        we_d     = we_q;
        regw_d   = regw_q;
        squash_d = squash_q;
        rd_d     = rd_q;
        f3_d     = f3_q;
        cnt_d    = cnt_q;
        wbv_d    = 1'b0;
        mis_d    = 1'b0;
        berr_d   = 1'b0;
        wbrw_d   = wbrw_q;
        mdata_d  = mdata_q;
        alu_d    = alu_q;
        rdo_d    = rdo_q;

        case (state_q)
            IDLE: begin
                if (ex_valid && !flush) begin
                    alu_d = alu_result_in;
                    rdo_d = rd_in;
                    if (mem_read_in || mem_write_in) begin
                        if (is_aligned(funct3_in[1:0], alu_result_in[1:0])) begin
                            state_d  = BUSY;
                            addr_d   = alu_result_in;
                            wdata_d  = store_data(funct3_in[1:0], write_data_in);
                            be_d     = byte_en(funct3_in[1:0], alu_result_in[1:0]);
                            we_d     = mem_write_in & ~mem_read_in;
                            regw_d   = reg_write_in & mem_read_in;
                            rd_d     = rd_in;
                            f3_d     = funct3_in;
                            cnt_d    = '0;
                            squash_d = 1'b0;
                        end else begin
                            wbv_d  = 1'b1;
                            mis_d  = 1'b1;
                            wbrw_d = 1'b0;
                        end
                    end else begin
                        wbv_d  = 1'b1;
                        wbrw_d = reg_write_in;
                    end
                end
            end
            BUSY: begin
                if (flush) squash_d = 1'b1;
                if (dmem_ack) begin
                    state_d = IDLE;
                    wbv_d   = ~kill;
                    wbrw_d  = regw_q;
                    rdo_d   = rd_q;
                    alu_d   = addr_q;
                    if (!we_q) mdata_d = load_data;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    // A squashed access that times out is dropped silently.
                    state_d = IDLE;
                    wbv_d   = ~kill;
                    berr_d  = ~kill;
                    wbrw_d  = 1'b0;
                    rdo_d   = rd_q;
                    alu_d   = addr_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            be_q     <= '0;
            we_q     <= 1'b0;
            regw_q   <= 1'b0;
            squash_q <= 1'b0;
            rd_q     <= '0;
            f3_q     <= '0;
            cnt_q    <= '0;
            wbv_q    <= 1'b0;
            wbrw_q   <= 1'b0;
            mis_q    <= 1'b0;
            berr_q   <= 1'b0;
            mdata_q  <= '0;
            alu_q    <= '0;
            rdo_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            be_q     <= be_d;
            we_q     <= we_d;
            regw_q   <= regw_d;
            squash_q <= squash_d;
            rd_q     <= rd_d;
            f3_q     <= f3_d;
            cnt_q    <= cnt_d;
            wbv_q    <= wbv_d;
            wbrw_q   <= wbrw_d;
            mis_q    <= mis_d;
            berr_q   <= berr_d;
            mdata_q  <= mdata_d;
            alu_q    <= alu_d;
            rdo_q    <= rdo_d;
        end
    end

    // Request and stall follow the state directly so reset drops them at once.
    assign stall_out      = (state_q == BUSY);
    assign dmem_req       = (state_q == BUSY);
    assign dmem_we        = we_q;
    assign dmem_addr      = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign dmem_wdata     = wdata_q;
    assign dmem_be        = be_q;
    assign wb_valid       = wbv_q;
    assign reg_write_out  = wbrw_q;
    assign mem_data_out   = mdata_q;
    assign alu_result_out = alu_q;
    assign rd_out         = rdo_q;
    assign misaligned_err = mis_q;
    assign bus_err        = berr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, reg_write_in, mem_read_in, mem_write_in, flush;
    logic [31:0] alu_result_in, write_data_in, dmem_rdata;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        dmem_ack;
    logic        dmem_req, dmem_we, wb_valid, reg_write_out, stall_out, misaligned_err, bus_err;
    logic [31:0] dmem_addr, dmem_wdata, mem_data_out, alu_result_out;
    logic [3:0]  dmem_be;
    logic [4:0]  rd_out;

    always #5 clk = ~clk;

    mem_access_unit #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .reg_write_in(reg_write_in),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .alu_result_in(alu_result_in),
        .write_data_in(write_data_in), .rd_in(rd_in), .funct3_in(funct3_in), .flush(flush),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .wb_valid(wb_valid),
        .reg_write_out(reg_write_out), .mem_data_out(mem_data_out), .alu_result_out(alu_result_out),
        .rd_out(rd_out), .stall_out(stall_out), .misaligned_err(misaligned_err), .bus_err(bus_err)
    );

    typedef struct {
        logic [31:0] data; logic chk_data; logic regw; logic [4:0] rd;
        logic mis; logic berr; logic [31:0] alu; logic chk_alu;
    } wb_t;

    typedef struct {
        logic rd_op; logic wr_op; logic [2:0] f3; logic [31:0] addr; logic [31:0] wdata;
        logic [31:0] rdata; int dly; logic [3:0] be; logic [31:0] wexp; logic [31:0] dexp; logic mis;
    } vec_t;

    wb_t  exp_q[$];
    vec_t vecs[15];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic vec_t mk(logic r, logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd,
                                logic [31:0] rdt, int dly, logic [3:0] be, logic [31:0] wexp,
                                logic [31:0] dexp, logic mis);
        vec_t v;
        v.rd_op = r; v.wr_op = w; v.f3 = f3; v.addr = a; v.wdata = wd; v.rdata = rdt;
        v.dly = dly; v.be = be; v.wexp = wexp; v.dexp = dexp; v.mis = mis;
        return v;
    endfunction

    // Scoreboard: every writeback must match the oldest pending expectation.
    always @(negedge clk) begin
        wb_t e;
        if (rst_n === 1'b1) begin
            if (wb_valid) begin
                if (exp_q.size() == 0) check("wb_unexpected", 64'(wb_valid), 64'd0);
                else begin
                    e = exp_q.pop_front();
                    check("wb_regw", 64'(reg_write_out), 64'(e.regw));
                    check("wb_rd", 64'(rd_out), 64'(e.rd));
                    check("wb_errs", {62'd0, misaligned_err, bus_err}, {62'd0, e.mis, e.berr});
                    if (e.chk_data) check("wb_mem_data", 64'(mem_data_out), 64'(e.data));
                    if (e.chk_alu)  check("wb_alu", 64'(alu_result_out), 64'(e.alu));
                end
            end else if (misaligned_err || bus_err) begin
                check("err_without_wb", {62'd0, misaligned_err, bus_err}, 64'd0);
            end
        end
    end

    task automatic idle_inputs();
        ex_valid = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0; flush = 1'b0;
        reg_write_in = 1'b0;
    endtask

    task automatic drive_op(logic r, logic w, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, logic [4:0] rd);
        ex_valid = 1'b1; mem_read_in = r; mem_write_in = w; funct3_in = f3;
        alu_result_in = a; write_data_in = wd; rd_in = rd; reg_write_in = 1'b1;
    endtask

    task automatic run_vec(vec_t v, int idx);
        wb_t e;
        int  n, exp_stall;
        logic mem;
        mem = v.rd_op | v.wr_op;
        @(negedge clk);
        drive_op(v.rd_op, v.wr_op, v.f3, v.addr, v.wdata, 5'(idx + 1));
        e.data = v.dexp; e.chk_data = v.rd_op && !v.mis && (v.dly != 0);
        e.regw = !v.mis && !v.wr_op && !(mem && v.dly == 0);
        e.rd = 5'(idx + 1); e.mis = v.mis; e.berr = mem && !v.mis && (v.dly == 0);
        e.alu = v.addr; e.chk_alu = !mem;
        exp_q.push_back(e);
        exp_stall = (!mem || v.mis) ? 0 : ((v.dly == 0) ? TO : v.dly);
        @(negedge clk);
        n = 0;
        while (stall_out && n < 20) begin
            n++;
            check($sformatf("v%0d_req_hold", idx), {31'd0, dmem_req, dmem_we, dmem_addr},
                  {31'd0, 1'b1, v.wr_op, v.addr & 32'hFFFF_FFFC});
            if (v.wr_op) check($sformatf("v%0d_store_lanes", idx), {28'd0, dmem_be, dmem_wdata}, {28'd0, v.be, v.wexp});
            if (n == v.dly) begin
                ex_valid = 1'b0; dmem_ack = 1'b1; dmem_rdata = v.rdata;
            end else begin
                // upstream junk while stalled must be ignored
                drive_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                         $urandom, $urandom, 5'h1F);
                dmem_rdata = $urandom;
            end
            @(negedge clk);
            dmem_ack = 1'b0;
        end
        idle_inputs();
        check($sformatf("v%0d_stall_cycles", idx), 64'(n), 64'(exp_stall));
        check($sformatf("v%0d_req_low", idx), 64'(dmem_req), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; dmem_ack = 1'b0; dmem_rdata = '0; alu_result_in = '0;
        write_data_in = '0; rd_in = '0; funct3_in = '0;
        idle_inputs();

        //              rd    wr    f3   addr        wdata         rdata         dly be     wexp          dexp          mis
        vecs[0]  = mk(1'b1, 1'b0, LW,  32'h100, 32'h0,        32'hDEADBEEF, 4, 4'h0, 32'h0,        32'hDEADBEEF, 1'b0);
        vecs[1]  = mk(1'b1, 1'b0, LB,  32'h103, 32'h0,        32'h80FF0000, 2, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0);
        vecs[2]  = mk(1'b1, 1'b0, LBU, 32'h103, 32'h0,        32'h80FF0000, 1, 4'h0, 32'h0,        32'h00000080, 1'b0);
        vecs[3]  = mk(1'b1, 1'b0, LH,  32'h102, 32'h0,        32'h80FF0000, 3, 4'h0, 32'h0,        32'hFFFF80FF, 1'b0);
        vecs[4]  = mk(1'b1, 1'b0, LHU, 32'h102, 32'h0,        32'h80FF0000, 1, 4'h0, 32'h0,        32'h000080FF, 1'b0);
        vecs[5]  = mk(1'b1, 1'b0, LB,  32'h101, 32'h0,        32'h00007F00, 1, 4'h0, 32'h0,        32'h0000007F, 1'b0);
        vecs[6]  = mk(1'b1, 1'b0, LH,  32'h100, 32'h0,        32'h12348765, 2, 4'h0, 32'h0,        32'hFFFF8765, 1'b0);
        vecs[7]  = mk(1'b0, 1'b1, SH,  32'h102, 32'h00001234, 32'h0,        2, 4'hC, 32'h12341234, 32'h0,        1'b0);
        vecs[8]  = mk(1'b0, 1'b1, SB,  32'h101, 32'h000000AB, 32'h0,        1, 4'h2, 32'hABABABAB, 32'h0,        1'b0);
        vecs[9]  = mk(1'b0, 1'b1, SW,  32'h104, 32'hCAFEF00D, 32'h0,        3, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0);
        vecs[10] = mk(1'b1, 1'b0, LW,  32'h101, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0,        1'b1);
        vecs[11] = mk(1'b1, 1'b0, LH,  32'h103, 32'h0,        32'h0,        1, 4'h0, 32'h0,        32'h0,        1'b1);
        vecs[12] = mk(1'b0, 1'b1, SW,  32'h102, 32'h5555AAAA, 32'h0,        1, 4'h0, 32'h0,        32'h0,        1'b1);
        vecs[13] = mk(1'b0, 1'b0, LB,  32'h55,  32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b0);
        vecs[14] = mk(1'b1, 1'b0, LW,  32'h200, 32'h0,        32'h0,        0, 4'h0, 32'h0,        32'h0,        1'b0);

        repeat (2) @(negedge clk);
        check("rst_port", {30'd0, dmem_req, dmem_we, dmem_addr}, 64'd0);
        check("rst_wdata_be", {28'd0, dmem_be, dmem_wdata}, 64'd0);
        check("rst_wb", {26'd0, wb_valid, reg_write_out, rd_out, stall_out, misaligned_err, bus_err}, 64'd0);
        check("rst_data", {mem_data_out, alu_result_out}, 64'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // flush in IDLE: ALU op and load both discarded
        @(negedge clk);
        drive_op(1'b0, 1'b0, LW, 32'h77, 32'h0, 5'd3); flush = 1'b1;
        @(negedge clk);
        check("flush_idle_alu_wb", 64'(wb_valid), 64'd0);
        drive_op(1'b1, 1'b0, LW, 32'h300, 32'h0, 5'd4); flush = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("flush_idle_load", {62'd0, stall_out, dmem_req}, 64'd0);
        check("flush_idle_load_wb", 64'(wb_valid), 64'd0);

        // flush in BUSY: request stays up, ack produces no writeback
        @(negedge clk);
        drive_op(1'b1, 1'b0, LW, 32'h400, 32'h0, 5'd5);
        @(negedge clk);
        idle_inputs();
        check("flush_busy_stall", 64'(stall_out), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_req_kept", {62'd0, stall_out, dmem_req}, 64'd3);
        dmem_ack = 1'b1; dmem_rdata = 32'h11223344;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("flush_busy_no_wb", {62'd0, wb_valid, stall_out}, 64'd0);

        // reset mid-BUSY drops the request at once; a late ack is ignored
        @(negedge clk);
        drive_op(1'b1, 1'b0, LW, 32'h500, 32'h0, 5'd6);
        @(negedge clk);
        idle_inputs();
        check("rst_busy_stall", 64'(stall_out), 64'd1);
        #2 rst_n = 1'b0;
        #1 check("rst_busy_req_drop", {61'd0, dmem_req, stall_out, wb_valid}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        dmem_ack = 1'b0;
        check("rst_late_ack", {62'd0, stall_out, wb_valid}, 64'd0);

        // normal operation resumes after the abandoned transaction
        run_vec(vecs[0], 20);
        run_vec(vecs[13], 21);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
